// File: rtl/audio_app.sv
// rtl/audio_app.sv - four-channel 16-bit audio router with a serially programmed routing table
module audio_app (
  input  logic        clk,
  input  logic        rst_,
  input  logic [15:0] di_0,
  input  logic [15:0] di_1,
  input  logic [15:0] di_2,
  input  logic [15:0] di_3,
  output logic [15:0] do_0,
  output logic [15:0] do_1,
  output logic [15:0] do_2,
  output logic [15:0] do_3,
  input  logic        prgrm_in,
  input  logic        prgrm_go_,
  output logic        err_
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ABORT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic [1:0]  sel_0;
  logic [1:0]  sel_1;
  logic [1:0]  sel_2;
  logic [1:0]  sel_3;
  logic        start_ok;
  logic        shift_en;
  logic        commit;
  logic        set_err;
  logic [15:0] di_arr [4];

  assign di_arr[0] = di_0;
  assign di_arr[1] = di_1;
  assign di_arr[2] = di_2;
  assign di_arr[3] = di_3;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // bit_cnt counts frame bits taken so far, including the command bit
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!prgrm_go_) begin
          if (prgrm_in) begin
            set_err   = 1'b1;
            state_nxt = ST_ABORT;
          end else begin
            start_ok  = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (!prgrm_go_) begin
          if (bit_cnt == 4'd9) begin
            set_err   = 1'b1;
            state_nxt = ST_ABORT;
          end else begin
            shift_en  = 1'b1;
          end
        end else begin
          if (bit_cnt == 4'd9) begin
            commit  = 1'b1;
          end else begin
            set_err = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (prgrm_go_) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      bit_cnt <= 4'd0;
      shift_q <= 8'd0;
    end else if (start_ok) begin
      bit_cnt <= 4'd1;
      shift_q <= 8'd0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 4'd1;
      shift_q <= {shift_q[6:0], prgrm_in};
    end
  end

  // sel_0 arrives first, so after eight shifts it sits in the top two bits
  always_ff @(posedge clk) begin
    if (!rst_) begin
      sel_0 <= 2'd0;
      sel_1 <= 2'd1;
      sel_2 <= 2'd2;
      sel_3 <= 2'd3;
    end else if (commit) begin
      sel_0 <= shift_q[7:6];
      sel_1 <= shift_q[5:4];
      sel_2 <= shift_q[3:2];
      sel_3 <= shift_q[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      err_ <= 1'b1;
    end else if (set_err) begin
      err_ <= 1'b0;
    end else if (start_ok) begin
      err_ <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      do_0 <= 16'd0;
      do_1 <= 16'd0;
      do_2 <= 16'd0;
      do_3 <= 16'd0;
    end else begin
      do_0 <= di_arr[sel_0];
      do_1 <= di_arr[sel_1];
      do_2 <= di_arr[sel_2];
      do_3 <= di_arr[sel_3];
    end
  end

endmodule

// File: tb/tb_audio_app.sv
// tb/tb_audio_app.sv - randomized self-checking bench for audio_app against a frame-level model
module tb_audio_app;

  logic        clk;
  logic        rst_;
  logic [15:0] di [4];
  logic        prgrm_in;
  logic        prgrm_go_;
  logic [15:0] do_0, do_1, do_2, do_3;
  logic        err_;
  logic [15:0] dut_do [4];

  int errors = 0;
  int checks = 0;

  // Reference model: whole frames are kept as a bit list and judged by length/command
  logic [1:0]  m_sel [4];
  logic [15:0] m_do [4];
  logic        m_err;
  bit          m_bits [$];

  audio_app dut (
    .clk       (clk),
    .rst_      (rst_),
    .di_0      (di[0]),
    .di_1      (di[1]),
    .di_2      (di[2]),
    .di_3      (di[3]),
    .do_0      (do_0),
    .do_1      (do_1),
    .do_2      (do_2),
    .do_3      (do_3),
    .prgrm_in  (prgrm_in),
    .prgrm_go_ (prgrm_go_),
    .err_      (err_)
  );

  assign dut_do[0] = do_0;
  assign dut_do[1] = do_1;
  assign dut_do[2] = do_2;
  assign dut_do[3] = do_3;

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic go, input logic b);
    rst_      = r;
    prgrm_go_ = go;
    prgrm_in  = b;
    @(posedge clk);
    if (!r) begin
      for (int n = 0; n < 4; n++) begin
        m_sel[n] = 2'(n);
        m_do[n]  = 16'h0;
      end
      m_err = 1'b1;
      m_bits.delete();
    end else begin
      for (int n = 0; n < 4; n++) m_do[n] = di[m_sel[n]];
      if (!go) begin
        m_bits.push_back(b);
        if (m_bits.size() == 1) m_err = !b;
        else if (m_bits.size() == 10 && m_bits[0] == 1'b0) m_err = 1'b0;
      end else if (m_bits.size() > 0) begin
        if (m_bits[0] == 1'b0) begin
          if (m_bits.size() == 9) begin
            for (int n = 0; n < 4; n++) m_sel[n] = {m_bits[1 + 2 * n], m_bits[2 + 2 * n]};
          end else if (m_bits.size() < 9) begin
            m_err = 1'b0;
          end
        end
        m_bits.delete();
      end
    end
    #1;
  endtask

  task automatic randomize_di();
    for (int n = 0; n < 4; n++) di[n] = 16'($urandom);
  endtask

  task automatic test_reset();
    randomize_di();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== 16'h0) begin
        errors++;
        $display("FAIL reset_do%0d: got %h expected 0000", n, dut_do[n]);
      end
    end
    checks++;
    if (err_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_err: got %b expected 1", err_);
    end
    di = '{16'h00f8, 16'h0, 16'h0, 16'h0};
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (do_0 !== 16'h00f8) begin
      errors++;
      $display("FAIL identity_do0: got %h expected 00f8", do_0);
    end
  endtask

  task automatic test_write_all_di0();
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0);
    di = '{16'h0123, 16'h1111, 16'h2222, 16'h3333};
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (err_ !== 1'b1) begin
      errors++;
      $display("FAIL write_err: got %b expected 1", err_);
    end
    checks++;
    if (do_1 !== 16'h1111) begin
      errors++;
      $display("FAIL commit_edge_old_sel: got %h expected 1111", do_1);
    end
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== 16'h0123) begin
        errors++;
        $display("FAIL write_route_do%0d: got %h expected 0123", n, dut_do[n]);
      end
    end
  endtask

  task automatic test_read();
    di[0] = 16'hff00;
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (err_ !== 1'b0) begin
      errors++;
      $display("FAIL read_err: got %b expected 0", err_);
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (do_0 !== 16'hff00 || err_ !== 1'b0) begin
      errors++;
      $display("FAIL read_unchanged: got do0=%h err=%b expected ff00 0", do_0, err_);
    end
  endtask

  task automatic test_short();
    int lens [5] = '{1, 2, 3, 5, 8};
    foreach (lens[k]) begin
      randomize_di();
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (err_ !== 1'b1) begin
        errors++;
        $display("FAIL short_start_err len%0d: got %b expected 1", lens[k], err_);
      end
      for (int i = 1; i < lens[k]; i++) tick(1'b1, 1'b0, 1'($urandom));
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (err_ !== 1'b0) begin
        errors++;
        $display("FAIL short_err len%0d: got %b expected 0", lens[k], err_);
      end
      randomize_di();
      tick(1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (dut_do[n] !== m_do[n]) begin
          errors++;
          $display("FAIL short_route_do%0d: got %h expected %h", n, dut_do[n], m_do[n]);
        end
      end
    end
  endtask

  task automatic test_long();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) tick(1'b1, 1'b0, 1'($urandom));
    checks++;
    if (err_ !== 1'b1) begin
      errors++;
      $display("FAIL long_9th_err: got %b expected 1", err_);
    end
    tick(1'b1, 1'b0, 1'($urandom));
    checks++;
    if (err_ !== 1'b0) begin
      errors++;
      $display("FAIL long_10th_err: got %b expected 0", err_);
    end
    tick(1'b1, 1'b0, 1'($urandom));
    tick(1'b1, 1'b1, 1'b0);
    randomize_di();
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== m_do[n] || err_ !== 1'b0) begin
        errors++;
        $display("FAIL long_no_commit_do%0d: got %h err=%b expected %h err=0", n, dut_do[n], err_, m_do[n]);
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_ !== 1'b1) begin
      errors++;
      $display("FAIL long_recover_err: got %b expected 1", err_);
    end
    for (int i = 1; i < 9; i++) tick(1'b1, 1'b0, 1'($urandom));
    tick(1'b1, 1'b1, 1'b0);
    randomize_di();
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== m_do[n] || err_ !== 1'b1) begin
        errors++;
        $display("FAIL long_recover_do%0d: got %h err=%b expected %h err=1", n, dut_do[n], err_, m_do[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) tick(1'b1, 1'b0, 1'($urandom));
    tick(1'b0, 1'b0, 1'($urandom));
    randomize_di();
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== di[n] || err_ !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_do%0d: got %h err=%b expected %h err=1", n, dut_do[n], err_, di[n]);
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) tick(1'b1, 1'b0, 1'($urandom));
    tick(1'b1, 1'b1, 1'b0);
    randomize_di();
    tick(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (dut_do[n] !== m_do[n] || err_ !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_after_do%0d: got %h err=%b expected %h err=1", n, dut_do[n], err_, m_do[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 150; f++) begin
      int len;
      int gap;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 9;
      gap = int'($urandom_range(1, 2));
      for (int i = 0; i < len + gap; i++) begin
        randomize_di();
        if (i == 0) tick(1'b1, 1'b0, ($urandom_range(0, 5) == 0));
        else if (i < len) tick(1'b1, 1'b0, 1'($urandom));
        else tick(1'b1, 1'b1, 1'($urandom));
        for (int n = 0; n < 4; n++) begin
          checks++;
          if (dut_do[n] !== m_do[n]) begin
            errors++;
            $display("FAIL b2b_do%0d frame%0d: got %h expected %h", n, f, dut_do[n], m_do[n]);
          end
        end
        checks++;
        if (err_ !== m_err) begin
          errors++;
          $display("FAIL b2b_err frame%0d: got %b expected %b", f, err_, m_err);
        end
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_      = 1'b0;
    prgrm_in  = 1'b0;
    prgrm_go_ = 1'b1;
    for (int n = 0; n < 4; n++) begin
      di[n]    = 16'h0;
      m_sel[n] = 2'(n);
      m_do[n]  = 16'h0;
    end
    m_err = 1'b1;
    test_reset();
    test_write_all_di0();
    test_read();
    test_short();
    test_long();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
